// File: rtl/spi_byte_ctrl.sv
// SPI mode-0 slave front end: oversamples SCLK/CS_n/MOSI in the CLK domain and
// sequences an external 8-bit shift register. States: IDLE (no frame) | ACTIVE (CS low, MISO driven).
module spi_byte_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [7:0] byte_idx,
  output logic       busy,
  output logic       sr_clr,
  output logic       sr_ld,
  output logic       sr_shift,
  output logic       sr_si,
  output logic [7:0] sr_din,
  input  logic [7:0] sr_dout,
  input  logic       sr_shiftout
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [2:0]             bit_cnt;
  logic                   byte_pend;
  logic                   byte_done;
  logic                   ld_d;
  logic                   miso_upd;

  // CS chain presets high so reset never looks like a frame start
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign busy   = (state == ACTIVE);
  assign sr_din = tx_data;

  always_comb begin
    state_nxt = state;
    sr_ld     = 1'b0;
    sr_shift  = 1'b0;
    sr_si     = 1'b0;
    sr_clr    = 1'b0;
    tx_req    = 1'b0;
    miso_upd  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          sr_ld     = 1'b1;
        end
      end
      ACTIVE: begin
        // CS release wins over a coincident SCLK edge
        if (cs_rise) begin
          state_nxt = IDLE;
          sr_clr    = 1'b1;
        end else if (sclk_rise) begin
          sr_shift = 1'b1;
          sr_si    = mosi_s;
          tx_req   = (bit_cnt == 3'd7);
        end else if (sclk_fall) begin
          if (byte_pend) sr_ld    = 1'b1;
          else           miso_upd = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      byte_pend   <= 1'b0;
      byte_done   <= 1'b0;
      ld_d        <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'd0;
      byte_idx    <= 8'd0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      spi_miso_oe <= (state_nxt == ACTIVE);
      ld_d        <= sr_ld;
      // byte pipeline keeps running across CS release so a finished byte is still reported
      byte_done   <= tx_req;
      rx_valid    <= byte_done;
      if (byte_done) rx_data <= sr_dout;

      if (state == IDLE && cs_fall) begin
        bit_cnt  <= 3'd0;
        byte_idx <= 8'd0;
      end else begin
        if (sr_clr)        bit_cnt <= 3'd0;
        else if (sr_shift) bit_cnt <= bit_cnt + 3'd1;
        if (rx_valid && byte_idx != 8'hFF) byte_idx <= byte_idx + 8'd1;
      end

      if (tx_req)                  byte_pend <= 1'b1;
      else if (sclk_fall || sr_clr) byte_pend <= 1'b0;

      if (sr_clr)                spi_miso <= 1'b0;
      else if (ld_d || miso_upd) spi_miso <= sr_shiftout;
    end
  end

endmodule

// File: tb/tb_spi_byte_ctrl.sv
// Randomised SPI master bench for spi_byte_ctrl with a behavioural shift register,
// a byte-level reference model and an rx scoreboard drained by a monitor process.
module tb_spi_byte_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] byte_idx;
  logic       busy, sr_clr, sr_ld, sr_shift, sr_si;
  logic [7:0] sr_din, sr_dout;
  logic       sr_shiftout;
  logic [7:0] sr_q;

  spi_byte_ctrl #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_req(tx_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .byte_idx(byte_idx), .busy(busy),
    .sr_clr(sr_clr), .sr_ld(sr_ld), .sr_shift(sr_shift), .sr_si(sr_si),
    .sr_din(sr_din), .sr_dout(sr_dout), .sr_shiftout(sr_shiftout)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the external 8-bit diagnostic shift register
  always @(posedge CLK or posedge RST) begin
    if (RST)           sr_q <= 8'd0;
    else if (sr_clr)   sr_q <= 8'd0;
    else if (sr_ld)    sr_q <= sr_din;
    else if (sr_shift) sr_q <= {sr_q[6:0], sr_si};
  end
  assign sr_dout     = sr_q;
  assign sr_shiftout = sr_q[7];

  int         checks = 0;
  int         errors = 0;
  int         txreq_cnt = 0;
  int         clr_cnt = 0;
  logic [15:0] sb_q[$];
  logic [7:0]  tx_next_q[$];
  logic [7:0]  mosi_b[$];
  logic [7:0]  tx_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (rx_valid) begin
          if (sb_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
          else begin
            e = sb_q.pop_front();
            check("rx_data", rx_data, e[15:8]);
            check("byte_idx", byte_idx, e[7:0]);
          end
        end
        if (tx_req) begin
          txreq_cnt++;
          if (tx_next_q.size() > 0) tx_data = tx_next_q.pop_front();
        end
        if (sr_clr) clr_cnt++;
        if (sr_ld && sr_shift) check("ld_shift_exclusive", 32'd1, 32'd0);
      end
    end
  endtask

  task automatic fill(input int n);
    mosi_b.delete();
    tx_b.delete();
    for (int i = 0; i <= n; i++) begin
      mosi_b.push_back(8'($urandom));
      tx_b.push_back(8'($urandom));
    end
  endtask

  task automatic send_bit(input logic b, input int hp, output logic m);
    spi_mosi = b;
    wait_clk(hp);
    m = spi_miso;
    spi_sclk = 1'b1;
    wait_clk(hp);
    spi_sclk = 1'b0;
  endtask

  // Master: nbytes full bytes, then pbits of a partial byte; late=1 releases CS
  // one clock after the final SCLK rise instead of after the final fall.
  task automatic run_frame(input int nbytes, input int pbits, input int hp, input bit late);
    logic       m;
    logic [7:0] got;
    int         c_req, c_clr;
    tx_data = tx_b[0];
    tx_next_q.delete();
    for (int k = 1; k <= nbytes; k++) tx_next_q.push_back(tx_b[k]);
    for (int k = 0; k < nbytes; k++)
      sb_q.push_back({mosi_b[k], (k > 255) ? 8'hFF : 8'(k)});
    c_req = txreq_cnt;
    c_clr = clr_cnt;
    spi_cs_n = 1'b0;
    wait_clk(hp);
    check("busy_active", busy, 1);
    check("oe_active", spi_miso_oe, 1);
    for (int k = 0; k < nbytes; k++) begin
      for (int i = 7; i >= 0; i--) begin
        if (late && k == nbytes - 1 && i == 0) begin
          spi_mosi = mosi_b[k][i];
          wait_clk(hp);
          m = spi_miso;
          spi_sclk = 1'b1;
          wait_clk(1);
          spi_cs_n = 1'b1;
          wait_clk(hp);
          spi_sclk = 1'b0;
        end else begin
          send_bit(mosi_b[k][i], hp, m);
        end
        got[i] = m;
      end
      check("miso_byte", got, tx_b[k]);
    end
    for (int p = 0; p < pbits; p++) send_bit(mosi_b[nbytes][7-p], hp, m);
    if (!late) begin
      wait_clk(hp);
      spi_cs_n = 1'b1;
    end
    wait_clk(2 * hp + 6);
    check("busy_idle", busy, 0);
    check("oe_idle", spi_miso_oe, 0);
    check("miso_idle", spi_miso, 0);
    check("tx_req_count", txreq_cnt - c_req, nbytes);
    check("sr_clr_count", clr_cnt - c_clr, 1);
    check("rx_outstanding", sb_q.size(), 0);
    tx_next_q.delete();
  endtask

  initial begin
    logic m;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tx_data  = 8'h00;
    fork
      monitor();
    join_none
    wait_clk(4);
    RST = 1'b0;
    wait_clk(4);
    check("reset_outputs",
          {spi_miso, spi_miso_oe, tx_req, rx_valid, busy, sr_clr, sr_ld, sr_shift, sr_si, rx_data, byte_idx},
          32'd0);

    // single byte
    mosi_b = '{8'h3C, 8'h00};
    tx_b   = '{8'hA5, 8'h5A};
    run_frame(1, 0, 8, 1'b0);

    // three-byte frame
    mosi_b = '{8'h01, 8'h80, 8'hFF, 8'h00};
    tx_b   = '{8'hA5, 8'h11, 8'h22, 8'h33};
    run_frame(3, 0, 7, 1'b0);

    // abort after five bits, then a fresh frame must restart at index 0
    fill(0);
    run_frame(0, 5, 8, 1'b0);
    fill(2);
    run_frame(2, 0, 6, 1'b0);

    // CS released one clock after the final SCLK rise
    fill(2);
    run_frame(2, 0, 8, 1'b1);

    // reset in the middle of a byte
    fill(1);
    tx_data = tx_b[0];
    spi_cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 3; i++) send_bit(mosi_b[0][7-i], 8, m);
    wait_clk(2);
    #2 RST = 1'b1;
    #1;
    check("reset_async_outputs",
          {spi_miso, spi_miso_oe, tx_req, rx_valid, busy, sr_clr, sr_ld, sr_shift, sr_si, rx_data, byte_idx},
          32'd0);
    spi_cs_n = 1'b1;
    tx_next_q.delete();
    wait_clk(4);
    RST = 1'b0;
    wait_clk(12);
    check("rx_after_reset", sb_q.size(), 0);
    mosi_b = '{8'h3C, 8'h00};
    tx_b   = '{8'hA5, 8'h5A};
    run_frame(1, 0, 8, 1'b0);

    // random frames, some with a trailing partial byte
    for (int f = 0; f < 10; f++) begin
      int n, pb, hp;
      n  = $urandom_range(1, 4);
      pb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      hp = $urandom_range(6, 10);
      fill(n);
      run_frame(n, pb, hp, 1'b0);
    end

    // long frame: byte index saturates at 255
    fill(260);
    run_frame(260, 0, 6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_byte_ctrl.md
Name: spi_byte_ctrl

Overview:
- Control stage directly upstream of the 8-bit diagnostic shift register in the AFC diagnostics Wishbone block.
- Oversamples an external SPI mode-0 slave interface (SCLK/CS_n/MOSI) in the system clock domain.
- Drives the shift register's clear/load/shift/serial-in controls and consumes its parallel and serial outputs.
- Frames received bytes to the register bank and fetches transmit bytes from it.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each input synchroniser (allowed 2..4)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  asynchronous, active-high reset
spi_sclk  input  1  external SPI clock, asynchronous to CLK
spi_cs_n  input  1  external chip select, active low, asynchronous
spi_mosi  input  1  external serial data in, asynchronous
spi_miso  output  1  serial data out, registered
spi_miso_oe  output  1  MISO driver enable, registered
tx_data  input  8  next byte to transmit, sampled on each sr_ld cycle
tx_req  output  1  one-cycle pulse: tx_data will be consumed at the next load
rx_data  output  8  last complete received byte, registered
rx_valid  output  1  one-cycle pulse: rx_data/byte_idx valid
byte_idx  output  8  index of byte within current frame
busy  output  1  frame in progress (synchronised CS active)
sr_clr  output  1  shift register synchronous clear
sr_ld  output  1  shift register parallel load
sr_shift  output  1  shift register shift enable
sr_si  output  1  shift register serial input
sr_din  output  8  shift register load data (equals tx_data, combinational)
sr_dout  input  8  shift register parallel output
sr_shiftout  input  1  shift register MSB

Behaviour:
- Reset (RST=1, asynchronous): all outputs 0 except internal CS synchroniser chain preset to 1 (inactive). bit_cnt=0, byte_idx=0, state IDLE.
- Synchronisers: SYNC_STAGES-deep chains on sclk, cs_n, mosi, plus one extra register on sclk and cs_n for edge detection. All edges below refer to synchronised signals.
- States:
  - IDLE: busy=0, oe=0.
  - ACTIVE: busy=1, oe=1.
- IDLE->ACTIVE on CS falling edge. In that cycle:
  - sr_ld=1; bit_cnt=0; byte_idx=0.
  - An SCLK rise in the same cycle is ignored.
- Next cycle after any sr_ld: spi_miso <= sr_shiftout (tx_data[7]).
- ACTIVE, SCLK rising edge:
  - sr_shift=1 and sr_si=synced mosi.
  - bit_cnt increments mod 8.
  - If bit_cnt was 7: tx_req=1 in the same cycle and byte_done is set.
- byte_done pipeline, with N = cycle of the 8th sr_shift:
  - Cycle N+1: rx_data <= sr_dout.
  - Cycle N+2: rx_valid=1, with byte_idx equal to the index of that byte.
  - Cycle N+3: byte_idx increments, saturating at 255.
- ACTIVE, SCLK falling edge:
  - If the previous rise completed a byte: sr_ld=1 (loads tx_data); spi_miso updates the following cycle.
  - Otherwise: spi_miso <= sr_shiftout in the same cycle.
- SCLK rise and fall in the same cycle are impossible; sr_ld and sr_shift are never asserted together.
- ACTIVE->IDLE on CS rising edge:
  - sr_clr=1 for one cycle; bit_cnt=0; spi_miso=0; oe=0.
  - A partial byte (bit_cnt≠0) is discarded; no rx_valid.
  - A byte_done already in the pipeline still produces rx_valid.
- CS falling while still ACTIVE (glitch shorter than the synchroniser cannot be seen): no action.
- SCLK edges in IDLE are ignored.
- Reset asserted mid-frame returns to IDLE immediately; no pulses are emitted afterwards.
- Constraint: SCLK high/low time must each be ≥ SYNC_STAGES+3 CLK periods.

Test Plan:
1. Single byte: CS low, tx_data=0xA5, master sends 0x3C MSB first → MISO bits 1,0,1,0,0,1,0,1; one rx_valid with rx_data=0x3C, byte_idx=0; tx_req once; on CS high, sr_clr pulses and busy=0.
2. Three-byte frame: MOSI 0x01,0x80,0xFF; tx_data changed after each tx_req to 0x11,0x22 → rx_valid ×3 with byte_idx 0,1,2; MISO carries 0xA5,0x11,0x22.
3. Abort: CS high after 5 SCLK rises → no rx_valid, sr_clr=1 once, next frame's byte_idx starts at 0.
4. Late CS release: CS rises 1 CLK after the synced 8th SCLK rise → rx_valid still pulses with the correct byte.
5. Reset mid-byte: RST pulse after 3 bits → all outputs 0 asynchronously; no rx_valid; a new frame after release works as in test 1.
6. Saturation: 260-byte frame → byte_idx 0..255, then stays 255 for bytes 256–259; rx_valid ×260.
